// File: rtl/exc_pkg.sv
// exc_pkg: shared definitions for the exception/interrupt sequencer.
//   - Cause.ExcCode values
//   - CP0 register indices targeted by the write-enable vector
//   - exc_flags bit positions
//   - sequencer state type
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int unsigned CP0_BADVADDR = 8;
    localparam int unsigned CP0_STATUS   = 12;
    localparam int unsigned CP0_CAUSE    = 13;
    localparam int unsigned CP0_EPC      = 14;

    localparam int unsigned FLG_ADEL_IF = 0;
    localparam int unsigned FLG_RI      = 1;
    localparam int unsigned FLG_OV      = 2;
    localparam int unsigned FLG_SYS     = 3;
    localparam int unsigned FLG_BP      = 4;
    localparam int unsigned FLG_ADEL_LS = 5;
    localparam int unsigned FLG_ADES    = 6;
    localparam int unsigned FLG_ERET    = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        REDIRECT = 2'd2
    } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: combinational priority encoder for the committing instruction.
// Ports:
//   exc_flags      in  8  raw exception flags (bit map in exc_pkg)
//   int_pending    in  1  enabled interrupt is pending
//   take           out 1  something must be handled (exception, interrupt or ERET)
//   is_eret        out 1  winner is ERET (no exception, no interrupt)
//   exccode        out 5  Cause.ExcCode of the winner
//   use_if_addr    out 1  BadVAddr comes from the fetch address
//   write_badvaddr out 1  winner is an address error, BadVAddr must be written
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [7:0] exc_flags,
    input  logic       int_pending,
    output logic       take,
    output logic       is_eret,
    output logic [4:0] exccode,
    output logic       use_if_addr,
    output logic       write_badvaddr
);

    always_comb begin
        take           = 1'b1;
        is_eret        = 1'b0;
        exccode        = EXC_INT;
        use_if_addr    = 1'b0;
        write_badvaddr = 1'b0;
        if (int_pending) begin
            exccode = EXC_INT;
        end else if (exc_flags[FLG_ADEL_IF]) begin
            exccode        = EXC_ADEL;
            use_if_addr    = 1'b1;
            write_badvaddr = 1'b1;
        end else if (exc_flags[FLG_RI]) begin
            exccode = EXC_RI;
        end else if (exc_flags[FLG_OV]) begin
            exccode = EXC_OV;
        end else if (exc_flags[FLG_SYS]) begin
            exccode = EXC_SYS;
        end else if (exc_flags[FLG_BP]) begin
            exccode = EXC_BP;
        end else if (exc_flags[FLG_ADEL_LS]) begin
            exccode        = EXC_ADEL;
            write_badvaddr = 1'b1;
        end else if (exc_flags[FLG_ADES]) begin
            exccode        = EXC_ADES;
            write_badvaddr = 1'b1;
        end else if (exc_flags[FLG_ERET]) begin
            is_eret = 1'b1;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer between MEM/WB commit and CP0.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   commit_valid/pc/bd           committing instruction
//   exc_flags                    exception flags of committing instruction
//   bad_if_addr, bad_ls_addr     faulting fetch / load-store address
//   hw_int                       asynchronous interrupt lines (synchronised here)
//   status_in, cause_in, epc_in  current CP0 state
//   cp0_we                       per-register write enable (bit n = CP0 reg n)
//   cp0_epc/badvaddr/exccode/bd  CP0 field write data
//   cp0_hw_int                   synchronised interrupt lines for Cause.IP
//   cp0_int_mask, cp0_exl, cp0_ie Status field write data
//   flush                        kill in-flight instructions (WRITE cycle)
//   redirect_valid/pc/ready      redirect handshake towards IF
//   busy                         controller is sequencing, commit stalled
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned          WIDTH      = 32,
    parameter logic [WIDTH-1:0]     EXC_VECTOR = 32'hBFC00380
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_valid,
    input  logic [WIDTH-1:0] commit_pc,
    input  logic             commit_bd,
    input  logic [7:0]       exc_flags,
    input  logic [WIDTH-1:0] bad_if_addr,
    input  logic [WIDTH-1:0] bad_ls_addr,
    input  logic [5:0]       hw_int,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] cause_in,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] cp0_we,
    output logic [WIDTH-1:0] cp0_epc,
    output logic [WIDTH-1:0] cp0_badvaddr,
    output logic [4:0]       cp0_exccode,
    output logic             cp0_bd,
    output logic [5:0]       cp0_hw_int,
    output logic [7:0]       cp0_int_mask,
    output logic             cp0_exl,
    output logic             cp0_ie,
    output logic             flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    input  logic             redirect_ready,
    output logic             busy
);

    exc_state_e       state_q, state_d;
    logic [5:0]       hw_meta_q, hw_sync_q;
    logic             is_eret_q, is_eret_d;
    logic [4:0]       code_q, code_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             bd_q, bd_d;
    logic [WIDTH-1:0] badv_q, badv_d;
    logic             wbad_q, wbad_d;
    logic [WIDTH-1:0] redir_q, redir_d;

    logic             int_pending;
    logic             p_take, p_eret, p_use_if, p_wbad;
    logic [4:0]       p_code;

    logic             unused_bits;
    assign unused_bits = ^{status_in[WIDTH-1:16], status_in[7:2],
                           cause_in[WIDTH-1:10], cause_in[7:0]};

    // IE set, EXL clear, and any enabled IP bit (HW lines above the two SW bits).
    assign int_pending = status_in[0] & ~status_in[1]
                       & |({hw_sync_q, cause_in[9:8]} & status_in[15:8]);

    exc_prio_enc u_prio (
        .exc_flags      (exc_flags),
        .int_pending    (int_pending),
        .take           (p_take),
        .is_eret        (p_eret),
        .exccode        (p_code),
        .use_if_addr    (p_use_if),
        .write_badvaddr (p_wbad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hw_meta_q <= '0;
            hw_sync_q <= '0;
            is_eret_q <= 1'b0;
            code_q    <= '0;
            pc_q      <= '0;
            bd_q      <= 1'b0;
            badv_q    <= '0;
            wbad_q    <= 1'b0;
            redir_q   <= '0;
        end else begin
            state_q   <= state_d;
            hw_meta_q <= hw_int;
            hw_sync_q <= hw_meta_q;
            is_eret_q <= is_eret_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
            bd_q      <= bd_d;
            badv_q    <= badv_d;
            wbad_q    <= wbad_d;
            redir_q   <= redir_d;
        end
    end

    // Next state and latched transaction fields.
    always_comb begin
        state_d   = state_q;
        is_eret_d = is_eret_q;
        code_d    = code_q;
        pc_d      = pc_q;
        bd_d      = bd_q;
        badv_d    = badv_q;
        wbad_d    = wbad_q;
        redir_d   = redir_q;
        unique case (state_q)
            IDLE: begin
                if (commit_valid && p_take) begin
                    state_d   = WRITE;
                    is_eret_d = p_eret;
                    code_d    = p_code;
                    pc_d      = commit_pc;
                    bd_d      = commit_bd;
                    badv_d    = p_use_if ? bad_if_addr : bad_ls_addr;
                    wbad_d    = p_wbad;
                end
            end
            WRITE: begin
                state_d = REDIRECT;
                // ERET returns to the EPC as seen during the write cycle.
                redir_d = is_eret_q ? epc_in : EXC_VECTOR;
            end
            REDIRECT: begin
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; CP0 data only meaningful in WRITE.
    always_comb begin
        cp0_we         = '0;
        cp0_epc        = '0;
        cp0_badvaddr   = '0;
        cp0_exccode    = '0;
        cp0_bd         = 1'b0;
        cp0_int_mask   = 8'hFF;
        cp0_exl        = 1'b0;
        cp0_ie         = 1'b1;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        busy           = 1'b0;
        unique case (state_q)
            WRITE: begin
                flush        = 1'b1;
                busy         = 1'b1;
                cp0_int_mask = status_in[15:8];
                cp0_ie       = status_in[0];
                cp0_we[CP0_STATUS] = 1'b1;
                if (!is_eret_q) begin
                    cp0_we[CP0_CAUSE]    = 1'b1;
                    cp0_we[CP0_EPC]      = 1'b1;
                    cp0_we[CP0_BADVADDR] = wbad_q;
                    cp0_epc      = pc_q;
                    cp0_bd       = bd_q;
                    cp0_badvaddr = badv_q;
                    cp0_exccode  = code_q;
                    cp0_exl      = 1'b1;
                end
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                busy           = 1'b1;
            end
            default: ;
        endcase
    end

    assign cp0_hw_int  = hw_sync_q;
    assign redirect_pc = redir_q;

endmodule
